// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch/execute-side signal bundle for fetch_queue
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    IMEM_ADDR;
    logic [31:0]   IMEM_DATA;
    logic          LE;
    logic          J;
    logic [7:0]    TA;
    logic          OUT_VALID;
    logic [7:0]    OUT_PC;
    logic [31:0]   OUT_INSTR;
    logic [CW-1:0] COUNT;
    logic          FULL;

    // Environment side: instruction memory plus consumer/execute controls.
    modport master (
        output IMEM_DATA, LE, J, TA,
        input  IMEM_ADDR, OUT_VALID, OUT_PC, OUT_INSTR, COUNT, FULL
    );

    // Queue side.
    modport slave (
        input  IMEM_DATA, LE, J, TA,
        output IMEM_ADDR, OUT_VALID, OUT_PC, OUT_INSTR, COUNT, FULL
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch FIFO with redirect flush
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [7:0]  RESET_PC = 8'd0
) (
    input  logic          CLK,
    input  logic          RST,
    fetch_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [7:0]    fetch_pc;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;

    // Entry storage is plain registers with no reset; only head..tail-1 is ever observed.
    logic [7:0]    pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic empty;
    logic full;
    logic pop;
    logic push;

    // Handshake decisions: a redirect suppresses both push and pop; a full
    // queue still accepts a push when the head leaves in the same cycle.
    always_comb begin
        empty = (count == '0);
        full  = (count == FULL_CNT);
        pop   = bus.LE && !empty && !bus.J;
        push  = !bus.J && (!full || pop);
    end

    // Pointer, occupancy and fetch PC state; reset beats redirect beats push/pop.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (bus.J) begin
            fetch_pc <= bus.TA;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                tail     <= tail + PW'(1);
                fetch_pc <= fetch_pc + 8'd4;
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            if (push && !pop) begin
                count <= count + (PW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (PW+1)'(1);
            end
        end
    end

    // Tail write of the word fetched at the current PC.
    always_ff @(posedge CLK) begin
        if (RST && push) begin
            pc_mem[tail]    <= fetch_pc;
            instr_mem[tail] <= bus.IMEM_DATA;
        end
    end

    // Head view; an empty queue shows a NOP at the fetch PC rather than
    // forwarding the word being written this cycle.
    always_comb begin
        bus.IMEM_ADDR = fetch_pc;
        bus.COUNT     = count;
        bus.FULL      = full;
        bus.OUT_VALID = !empty;
        if (empty) begin
            bus.OUT_PC    = fetch_pc;
            bus.OUT_INSTR = 32'h0;
        end else begin
            bus.OUT_PC    = pc_mem[head];
            bus.OUT_INSTR = instr_mem[head];
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue
module tb_fetch_queue;
    localparam int         DEPTH    = 4;
    localparam logic [7:0] RESET_PC = 8'd0;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] tag(input logic [7:0] a);
        return 32'hC0DE_0000 | {24'h0, a} | ({24'h0, ~a} << 8);
    endfunction

    // Instruction memory returns an address-tagged word combinationally.
    assign bus.IMEM_DATA = tag(bus.IMEM_ADDR);

    int errors = 0;
    int checks = 0;

    logic [7:0] mq[$];
    logic [7:0] mpc;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // One clock: drive, check against the model, clock, advance the model.
    task automatic cycle(input logic rst, input logic le, input logic j, input logic [7:0] ta);
        logic p;
        logic ps;
        RST = rst;
        bus.LE = le;
        bus.J  = j;
        bus.TA = ta;
        #1;
        chk("count", 32'(bus.COUNT), 32'(mq.size()));
        chk("valid", 32'(bus.OUT_VALID), 32'(mq.size() != 0));
        chk("full", 32'(bus.FULL), 32'(mq.size() == DEPTH));
        chk("imem_addr", 32'(bus.IMEM_ADDR), 32'(mpc));
        if (mq.size() == 0) begin
            chk("empty_instr", bus.OUT_INSTR, 32'h0);
            chk("empty_pc", 32'(bus.OUT_PC), 32'(mpc));
        end
        p = rst && !j && le && (mq.size() > 0);
        if (p) begin
            chk("pop_pc", 32'(bus.OUT_PC), 32'(mq[0]));
            chk("pop_instr", bus.OUT_INSTR, tag(mq[0]));
        end
        @(posedge CLK);
        if (!rst) begin
            mq.delete();
            mpc = RESET_PC;
        end else if (j) begin
            mq.delete();
            mpc = ta;
        end else begin
            ps = (mq.size() < DEPTH) || p;
            if (p) void'(mq.pop_front());
            if (ps) begin
                mq.push_back(mpc);
                mpc = mpc + 8'd4;
            end
        end
        #1;
    endtask

    initial begin
        bus.LE = 1'b0;
        bus.J  = 1'b0;
        bus.TA = 8'h0;
        RST    = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        mpc = RESET_PC;

        // Reset state
        chk("rst_count", 32'(bus.COUNT), 32'd0);
        chk("rst_valid", 32'(bus.OUT_VALID), 32'd0);
        chk("rst_instr", bus.OUT_INSTR, 32'h0);
        chk("rst_full", 32'(bus.FULL), 32'd0);
        chk("rst_addr", 32'(bus.IMEM_ADDR), 32'(RESET_PC));

        // Fill with consumer stalled
        repeat (4) cycle(1'b1, 1'b0, 1'b0, 8'h00);
        chk("fill_count", 32'(bus.COUNT), 32'd4);
        chk("fill_full", 32'(bus.FULL), 32'd1);
        chk("fill_pc", 32'(bus.OUT_PC), 32'h00);
        chk("fill_addr", 32'(bus.IMEM_ADDR), 32'h10);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        chk("fill_hold_addr", 32'(bus.IMEM_ADDR), 32'h10);

        // Streaming from full
        for (int i = 0; i < 6; i++) begin
            chk("stream_pc", 32'(bus.OUT_PC), 32'(i * 4));
            chk("stream_count", 32'(bus.COUNT), 32'd4);
            cycle(1'b1, 1'b1, 1'b0, 8'h00);
        end

        // Redirect with three entries queued and LE high
        cycle(1'b1, 1'b0, 1'b1, 8'h80);
        chk("j_empty_pc", 32'(bus.OUT_PC), 32'h80);
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 8'h00);
        chk("pre_redirect_count", 32'(bus.COUNT), 32'd3);
        cycle(1'b1, 1'b1, 1'b1, 8'h40);
        chk("redir_count", 32'(bus.COUNT), 32'd0);
        chk("redir_valid", 32'(bus.OUT_VALID), 32'd0);
        chk("redir_addr", 32'(bus.IMEM_ADDR), 32'h40);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        chk("redir_pc", 32'(bus.OUT_PC), 32'h40);
        chk("redir_valid1", 32'(bus.OUT_VALID), 32'd1);

        // Underflow: LE pulses while reset blocks pushes
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 8'h00);
            chk("uf_count", 32'(bus.COUNT), 32'd0);
            chk("uf_instr", bus.OUT_INSTR, 32'h0);
        end

        // PC wrap across 8'hFF
        cycle(1'b1, 1'b1, 1'b1, 8'hF8);
        cycle(1'b1, 1'b1, 1'b0, 8'h00);
        chk("wrap0", 32'(bus.OUT_PC), 32'hF8);
        cycle(1'b1, 1'b1, 1'b0, 8'h00);
        chk("wrap1", 32'(bus.OUT_PC), 32'hFC);
        cycle(1'b1, 1'b1, 1'b0, 8'h00);
        chk("wrap2", 32'(bus.OUT_PC), 32'h00);
        cycle(1'b1, 1'b1, 1'b0, 8'h00);
        chk("wrap3", 32'(bus.OUT_PC), 32'h04);

        // Reset beats a redirect in the same cycle
        cycle(1'b1, 1'b0, 1'b1, 8'h20);
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 8'h00);
        chk("mid_count", 32'(bus.COUNT), 32'd2);
        cycle(1'b0, 1'b0, 1'b1, 8'h60);
        chk("rst_j_count", 32'(bus.COUNT), 32'd0);
        chk("rst_j_addr", 32'(bus.IMEM_ADDR), 32'(RESET_PC));
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        chk("rst_first_pc", 32'(bus.OUT_PC), 32'(RESET_PC));
        chk("rst_first_count", 32'(bus.COUNT), 32'd1);

        // Random traffic under the scoreboard
        for (int i = 0; i < 60; i++) begin
            cycle($urandom_range(0, 19) != 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 7) == 0, 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
